// File: rtl/ofdm_pkg.sv
// ofdm_pkg: burst geometry and framer FSM states shared by the transmit
// framer and the receive synchronizer / CP remover.
package ofdm_pkg;

  localparam int FFT_POINT   = 64;   // samples per symbol body
  localparam int CP_NUM      = 16;   // cyclic prefix length
  localparam int SYM_NUM     = 12;   // 2 time-sync + 2 channel-est + 8 data
  localparam int GAP_LEN     = 80;   // zero samples per padding gap
  localparam int GAP_AFTER_A = 1;    // symbol index followed by first gap
  localparam int GAP_AFTER_B = 3;    // symbol index followed by second gap

  // Total samples on the wire for one burst (1120 with the defaults).
  localparam int BURST_LEN = SYM_NUM * (CP_NUM + FFT_POINT) + 2 * GAP_LEN;

  localparam int ADDR_W = $clog2(FFT_POINT);
  localparam int CNT_W  = $clog2((GAP_LEN > FFT_POINT) ? GAP_LEN : FFT_POINT);
  localparam int SYM_W  = $clog2(SYM_NUM + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY,
    ST_GAP
  } framer_state_e;

endpackage

// File: rtl/framer_pingpong_buf.sv
// framer_pingpong_buf: two FFT_POINT-deep sample banks with per-bank full
// flags. Input fills the banks alternately; the reader releases a bank once
// it has replayed it. Read data is registered (one-cycle latency).
module framer_pingpong_buf
  import ofdm_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_ready,
  input  logic              rel_en,
  input  logic              rel_bank,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic [1:0]        full
);

  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              wr_fire;
  logic [DW-1:0]     mem_q [2][FFT_POINT];
  logic [DW-1:0]     rd_data_q;

  // A bank released this cycle can take its first new sample in the same cycle.
  assign wr_ready = !full_q[wr_bank_q] || (rel_en && (rel_bank == wr_bank_q));
  assign wr_fire  = wr_valid && wr_ready;
  assign full     = full_q;
  assign rd_data  = rd_data_q;

  // Advance the write pointer; mark a bank full on its last entry, clear on release.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    if (rel_en) begin
      full_d[rel_bank] = 1'b0;
    end
    if (wr_fire) begin
      if (wr_ptr_q == ADDR_W'(FFT_POINT - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_ptr_d          = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // Write pointer and bank flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      full_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
    end
  end

  // Sample storage with a registered read port.
  // NOTE: storage is not reset; entries are always written before being read, and this keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_ptr_q] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/ofdm_burst_framer.sv
// ofdm_burst_framer: takes IFFT symbols, prepends a cyclic prefix to each,
// inserts zero gaps after symbols GAP_AFTER_A and GAP_AFTER_B, and streams one
// BURST_LEN-sample burst. The read FSM issues one buffer read (or one zero)
// per cycle into a two-stage output path: the registered buffer read, then a
// registered output with a one-entry skid so m_ready back-pressure costs no
// throughput.
// Optional: define FRAMER_STATS_EN to add burst_cnt and underrun_cnt outputs.
module ofdm_burst_framer
  import ofdm_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sof,
  output logic          m_last,
  output logic          busy
`ifdef FRAMER_STATS_EN
  ,
  output logic [15:0]   burst_cnt,
  output logic [15:0]   underrun_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic valid;
    logic zero;
    logic sof;
    logic last;
  } issue_t;

  framer_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYM_W-1:0]  sym_idx_q, sym_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic              busy_q, busy_d;
  issue_t            p1_q, p1_d;
  beat_t             out_q, out_d, skid_q, skid_d, land_beat;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  logic              rel_en, rd_en, stall, space, pop, last_pop;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic [1:0]        full, occ;
  logic              bank_full;

  framer_pingpong_buf #(.DW(DW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (s_valid),
    .wr_data  (s_data),
    .wr_ready (s_ready),
    .rel_en   (rel_en),
    .rel_bank (rd_bank_q),
    .rd_en    (rd_en),
    .rd_bank  (rd_bank_q),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .full     (full)
  );

  assign bank_full = full[rd_bank_q];
  assign pop       = out_valid_q && m_ready;
  assign last_pop  = pop && out_q.last;
  // Beats held or in flight; a new issue is allowed if, after this cycle's pop,
  // the output register plus skid can still absorb it.
  assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(p1_q.valid);
  assign space = (occ - 2'(pop)) < 2'd2;
  assign rd_en = p1_d.valid && !p1_d.zero;

  // Read FSM: choose what to issue this cycle and where to go next.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sym_idx_d = sym_idx_q;
    rd_bank_d = rd_bank_q;
    busy_d    = busy_q;
    p1_d      = '0;
    rd_addr   = '0;
    rel_en    = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The first CP read is issued straight from IDLE to save a cycle.
        if (!busy_q && bank_full && space) begin
          p1_d.valid = 1'b1;
          p1_d.sof   = 1'b1;
          rd_addr    = ADDR_W'(FFT_POINT - CP_NUM);
          cnt_d      = CNT_W'(1);
          sym_idx_d  = '0;
          busy_d     = 1'b1;
          state_d    = ST_CP;
        end
      end
      ST_CP: begin
        if (!bank_full) begin
          stall = 1'b1;   // next symbol not yet written: wait in place
        end else if (space) begin
          p1_d.valid = 1'b1;
          rd_addr    = ADDR_W'(FFT_POINT - CP_NUM) + cnt_q[ADDR_W-1:0];
          if (cnt_q == CNT_W'(CP_NUM - 1)) begin
            cnt_d   = '0;
            state_d = ST_BODY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (space) begin
          p1_d.valid = 1'b1;
          rd_addr    = cnt_q[ADDR_W-1:0];
          if (cnt_q == CNT_W'(FFT_POINT - 1)) begin
            p1_d.last = (sym_idx_q == SYM_W'(SYM_NUM - 1));
            rel_en    = 1'b1;
            rd_bank_d = ~rd_bank_q;
            sym_idx_d = sym_idx_q + 1'b1;
            cnt_d     = '0;
            if (sym_idx_q == SYM_W'(GAP_AFTER_A) || sym_idx_q == SYM_W'(GAP_AFTER_B)) begin
              state_d = ST_GAP;
            end else if (sym_idx_q < SYM_W'(SYM_NUM - 1)) begin
              state_d = ST_CP;
            end else begin
              state_d = ST_IDLE;   // burst stays busy until m_last is taken
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (space) begin
          p1_d.valid = 1'b1;
          p1_d.zero  = 1'b1;
          if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_CP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (last_pop) begin
      busy_d    = 1'b0;
      sym_idx_d = '0;
      state_d   = ST_IDLE;
    end
  end

  // Output register plus skid: the head beat never changes while stalled.
  always_comb begin
    land_beat.data = p1_q.zero ? {DW{1'b0}} : rd_data;
    land_beat.sof  = p1_q.sof;
    land_beat.last = p1_q.last;
    out_d          = out_q;
    out_valid_d    = out_valid_q;
    skid_d         = skid_q;
    skid_valid_d   = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = p1_q.valid;
        if (p1_q.valid) skid_d = land_beat;
      end else begin
        out_valid_d = p1_q.valid;
        if (p1_q.valid) out_d = land_beat;
      end
    end else if (!out_valid_q) begin
      out_valid_d = p1_q.valid;
      if (p1_q.valid) out_d = land_beat;
    end else if (p1_q.valid) begin
      skid_valid_d = 1'b1;
      skid_d       = land_beat;
    end
  end

  // FSM, counters and output pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sym_idx_q    <= '0;
      rd_bank_q    <= 1'b0;
      busy_q       <= 1'b0;
      p1_q         <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sym_idx_q    <= sym_idx_d;
      rd_bank_q    <= rd_bank_d;
      busy_q       <= busy_d;
      p1_q         <= p1_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign m_valid = out_valid_q;
  assign m_data  = out_q.data;
  assign m_sof   = out_valid_q && out_q.sof;
  assign m_last  = out_valid_q && out_q.last;
  assign busy    = busy_q;

`ifdef FRAMER_STATS_EN
  logic [15:0] burst_cnt_q, burst_cnt_d, underrun_cnt_q, underrun_cnt_d;

  // Burst counter wraps; underrun counter saturates.
  always_comb begin
    burst_cnt_d    = burst_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    if (last_pop) burst_cnt_d = burst_cnt_q + 16'd1;
    if (stall && underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      burst_cnt_q    <= burst_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign burst_cnt    = burst_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
`else
  // Stall indication only feeds the optional statistics.
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_ofdm_burst_framer.sv
// tb_ofdm_burst_framer: random-handshake bench for ofdm_burst_framer. The
// expected burst is assembled from the input symbols by the framing rules
// (CP = last CP_NUM samples, body, zero gaps) and compared beat by beat.
module tb_ofdm_burst_framer;
  import ofdm_pkg::*;

  localparam int DW   = 8;
  localparam int N_IN = SYM_NUM * FFT_POINT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sof;
  logic          m_last;
  logic          busy;
`ifdef FRAMER_STATS_EN
  logic [15:0]   burst_cnt;
  logic [15:0]   underrun_cnt;
`endif

  ofdm_burst_framer #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sof   (m_sof),
    .m_last  (m_last),
    .busy    (busy)
`ifdef FRAMER_STATS_EN
    ,
    .burst_cnt    (burst_cnt),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          last;
  } beat_t;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] stim[$];
  beat_t         exp_q[$];
  logic [DW-1:0] out_log [2 * BURST_LEN];
  int            underrun_seen;
  int            acc63;
  int            first_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_s_ready"}, 32'(s_ready), 1);
    check({pfx, "_m_valid"}, 32'(m_valid), 0);
    check({pfx, "_m_data"},  32'(m_data),  0);
    check({pfx, "_m_sof"},   32'(m_sof),   0);
    check({pfx, "_m_last"},  32'(m_last),  0);
    check({pfx, "_busy"},    32'(busy),    0);
  endtask

  // Reference burst: for each symbol, its last CP_NUM samples, then the whole
  // symbol, then a zero gap after the two designated symbols.
  task automatic add_expected(input int base);
    beat_t b;
    int    src;
    for (int s = 0; s < SYM_NUM; s++) begin
      for (int k = 0; k < CP_NUM + FFT_POINT; k++) begin
        src    = (k < CP_NUM) ? (FFT_POINT - CP_NUM + k) : (k - CP_NUM);
        b.data = stim[base + s * FFT_POINT + src];
        b.sof  = (s == 0 && k == 0);
        b.last = (s == SYM_NUM - 1 && k == CP_NUM + FFT_POINT - 1);
        exp_q.push_back(b);
      end
      if (s == GAP_AFTER_A || s == GAP_AFTER_B) begin
        for (int g = 0; g < GAP_LEN; g++) begin
          b.data = '0; b.sof = 1'b0; b.last = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic make_ramp(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'(i % 256));
  endtask

  task automatic make_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'($urandom_range(255)));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive inputs #1 after each rising edge, observe at the falling edge;
  // a handshake seen at the falling edge completes on the next rising edge.
  task automatic run(input string name, input int n_bursts, input int ready_pct,
                     input int valid_pct, input int pause_at, input int pause_len,
                     input int abort_at);
    int    in_idx = 0, out_idx = 0, cyc = 0, pause_left = 0;
    bit    hold_v = 1'b0, started = 1'b0;
    beat_t hold_b, b;
    int    n_in = n_bursts * N_IN;
    for (int k = 0; k < n_bursts; k++) add_expected(k * N_IN);
    underrun_seen = 0; acc63 = -1; first_v = -1;
    while (exp_q.size() > 0) begin
      if (cyc >= 20000) begin
        check({name, "_timeout_left"}, 32'(exp_q.size()), 0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (pause_left > 0) begin
        pause_left--;
        s_valid = 1'b0;
      end else if (in_idx < n_in && int'($urandom_range(99)) < valid_pct) begin
        s_valid = 1'b1;
        s_data  = stim[in_idx];
      end else begin
        s_valid = 1'b0;
      end
      m_ready = int'($urandom_range(99)) < ready_pct;
      @(negedge clk);
      if (hold_v) begin
        check({name, "_hold_valid"}, 32'(m_valid), 1);
        check({name, "_hold_data"},  32'(m_data), 32'(hold_b.data));
        check({name, "_hold_sof"},   32'(m_sof),  32'(hold_b.sof));
        check({name, "_hold_last"},  32'(m_last), 32'(hold_b.last));
      end
      hold_v = m_valid && !m_ready;
      hold_b.data = m_data; hold_b.sof = m_sof; hold_b.last = m_last;
      if (m_valid && first_v < 0) first_v = cyc;
      if (started && busy && !m_valid) underrun_seen++;
      if (s_valid && s_ready) begin
        if (in_idx == FFT_POINT - 1 && acc63 < 0) acc63 = cyc;
        if (in_idx == pause_at) pause_left = pause_len;
        in_idx++;
      end
      if (m_valid && m_ready) begin
        b = exp_q.pop_front();
        check({name, "_data"}, 32'(m_data), 32'(b.data));
        check({name, "_sof"},  32'(m_sof),  32'(b.sof));
        check({name, "_last"}, 32'(m_last), 32'(b.last));
        if (out_idx < 2 * BURST_LEN) out_log[out_idx] = m_data;
        started = !m_last;
        out_idx++;
        if (abort_at >= 0 && out_idx == abort_at) break;
      end
    end
    if (abort_at < 0) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      check({name, "_busy_after"},    32'(busy),    0);
      check({name, "_valid_after"},   32'(m_valid), 0);
      check({name, "_s_ready_after"}, 32'(s_ready), 1);
`ifdef FRAMER_STATS_EN
      check({name, "_burst_cnt"}, 32'(burst_cnt), 32'(n_bursts));
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ramp, free-running sink: layout spot values and first-output latency.
    make_ramp(N_IN);
    run("ramp", 1, 100, 100, -1, 0, -1);
    check("ramp_latency", 32'(first_v - acc63 - 1), 2);
    check("ramp_out0",    32'(out_log[0]),    48);
    check("ramp_out15",   32'(out_log[15]),   63);
    check("ramp_out16",   32'(out_log[16]),   0);
    check("ramp_out79",   32'(out_log[79]),   63);
    check("ramp_out80",   32'(out_log[80]),   112);
    check("ramp_out95",   32'(out_log[95]),   127);
    check("ramp_out160",  32'(out_log[160]),  0);
    check("ramp_out239",  32'(out_log[239]),  0);
    check("ramp_out1119", 32'(out_log[1119]), 255);

    // Same burst under 50% back-pressure.
    reset_dut();
    make_ramp(N_IN);
    run("ramp_bp", 1, 50, 100, -1, 0, -1);

    // Input paused mid-burst: output must underrun and resume cleanly.
    reset_dut();
    make_ramp(N_IN);
    run("underrun", 1, 100, 100, 300, 100, -1);
    check("underrun_gap_seen", 32'(underrun_seen > 0), 1);
`ifdef FRAMER_STATS_EN
    check("underrun_cnt_nonzero", 32'(underrun_cnt != 0), 1);
`endif

    // Two back-to-back bursts from one continuous ramp.
    reset_dut();
    make_ramp(2 * N_IN);
    run("b2b", 2, 100, 100, -1, 0, -1);
    check("b2b_out1120", 32'(out_log[BURST_LEN]), 48);

    // Random data with random source and sink pacing.
    reset_dut();
    make_random(2 * N_IN);
    run("rand", 2, 60, 70, -1, 0, -1);

    // Reset in the middle of a burst, then a fresh burst.
    reset_dut();
    make_ramp(N_IN);
    run("abort", 1, 100, 100, -1, 0, 500);
    check("abort_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0;
    #1 check_reset("mid");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    make_ramp(N_IN);
    run("fresh", 1, 100, 100, -1, 0, -1);
    check("fresh_out0", 32'(out_log[0]), 48);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
